// File: rtl/mem_responder.sv
// Word-wide memory responder with a fixed number of wait states and a one-cycle ready pulse.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_ready,
   output logic              busy,
   output logic              misalign
);

   localparam int unsigned Depth = 2 ** (ADDR_W - 2);
   localparam logic [3:0] CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              rd_q, wr_q, mis_q;
   logic [ADDR_W-1:0] raddr_q, waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem_q [Depth];

   logic              accept, go_done, mem_we;
   logic              op_rd, op_wr, op_mis;
   logic [ADDR_W-1:0] op_raddr, op_waddr;
   logic [DATA_W-1:0] op_wdata;

   assign accept = (state_q == StIdle) && (MemRead || MemWrite);

   // With zero wait states the access completes on the accept edge, so the live inputs are used.
   always_comb begin
      op_rd    = rd_q;
      op_wr    = wr_q;
      op_raddr = raddr_q;
      op_waddr = waddr_q;
      op_wdata = wdata_q;
      if (state_q == StIdle) begin
         op_rd    = MemRead;
         op_wr    = MemWrite;
         op_raddr = raddr;
         op_waddr = waddr;
         op_wdata = wdata;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   always_comb begin
      op_mis = mis_q;
      if (state_q == StIdle) begin
         op_mis = (MemRead && (raddr[1:0] != 2'b00)) || (MemWrite && (waddr[1:0] != 2'b00));
      end
   end
`else
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{op_raddr[1:0], op_waddr[1:0], mis_q};
   assign op_mis = 1'b0;
`endif

   assign go_done = ((state_q == StBusy) && (cnt_q == 4'd0)) || (accept && (WAIT_CYCLES == 0));
   assign mem_we  = go_done && op_wr && !op_mis && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         mis_q     <= 1'b0;
         raddr_q   <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         rdata     <= '0;
         mem_ready <= 1'b0;
         busy      <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         misalign  <= 1'b0;
         if (accept) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            raddr_q <= raddr;
            waddr_q <= waddr;
            wdata_q <= wdata;
            mis_q   <= op_mis;
            cnt_q   <= CntInit;
            busy    <= 1'b1;
            state_q <= StBusy;
         end else if ((state_q == StBusy) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (go_done) begin
            state_q   <= StDone;
            mem_ready <= 1'b1;
            busy      <= 1'b1;
            misalign  <= op_mis;
            // Store is read before the same-edge write lands: read-before-write.
            if (op_rd && !op_mis) begin
               rdata <= mem_q[op_raddr[ADDR_W-1:2]];
            end
         end else if (state_q == StDone) begin
            state_q <= StIdle;
            busy    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[op_waddr[ADDR_W-1:2]] <= op_wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

`ifdef MEM_MISALIGN_CHECK_EN
   localparam bit MisEn = 1'b1;
`else
   localparam bit MisEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [7:0]  raddr = '0, waddr = '0;
   logic [31:0] wdata = '0, rdata;
   logic        mem_ready, busy, misalign;

   logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
   logic [7:0]  raddr0 = '0, waddr0 = '0;
   logic [31:0] wdata0 = '0, rdata0;
   logic        mem_ready0, busy0, misalign0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          r_lat, r_pulses, r_busy;
   logic [31:0] r_rdata;
   logic        r_mis;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
      .raddr(raddr), .waddr(waddr), .wdata(wdata), .rdata(rdata),
      .mem_ready(mem_ready), .busy(busy), .misalign(misalign)
   );

   mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .MemRead(mem_read0), .MemWrite(mem_write0),
      .raddr(raddr0), .waddr(waddr0), .wdata(wdata0), .rdata(rdata0),
      .mem_ready(mem_ready0), .busy(busy0), .misalign(misalign0)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One transaction; records latency (edges after accept), pulse count and busy cycles.
   task automatic txn(input bit sel, input logic rd, input logic wr, input logic [7:0] ra,
                      input logic [7:0] wa, input logic [31:0] wd, input bit disturb);
      @(negedge clk);
      if (!sel) begin
         mem_read = rd; mem_write = wr; raddr = ra; waddr = wa; wdata = wd;
      end else begin
         mem_read0 = rd; mem_write0 = wr; raddr0 = ra; waddr0 = wa; wdata0 = wd;
      end
      @(posedge clk);
      #1;
      mem_read = 1'b0; mem_write = 1'b0; mem_read0 = 1'b0; mem_write0 = 1'b0;
      if (disturb) begin
         waddr = 8'h20;
         wdata = 32'h0;
      end
      r_lat = -1; r_pulses = 0; r_busy = 0; r_rdata = '0; r_mis = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (sel ? mem_ready0 : mem_ready) begin
            if (r_lat < 0) begin
               r_lat   = n;
               r_rdata = sel ? rdata0 : rdata;
               r_mis   = sel ? misalign0 : misalign;
            end
            r_pulses++;
         end
         if (sel ? busy0 : busy) r_busy++;
      end
   endtask

   initial begin
      int pulses;

      // 1. Reset, then a write with two wait states
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rdata", rdata, 32'h0);
      check_eq("rst_ready", {31'd0, mem_ready}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
      rst_n = 1'b1;

      txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 32'hDEADBEEF, 1'b0);
      check_eq("wr_latency", 32'(r_lat), 32'd2);
      check_eq("wr_pulses", 32'(r_pulses), 32'd1);
      check_eq("wr_busy_cycles", 32'(r_busy), 32'd3);
      check_eq("wr_only_rdata_held", rdata, 32'h0);

      // 2. Read-back, aligned and unaligned
      txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 32'h0, 1'b0);
      check_eq("rd_0x10", r_rdata, 32'hDEADBEEF);
      check_eq("rd_latency", 32'(r_lat), 32'd2);
      txn(1'b0, 1'b1, 1'b0, 8'h13, 8'h00, 32'h0, 1'b0);
      check_eq("rd_0x13", r_rdata, 32'hDEADBEEF);
      check_eq("rd_0x13_misalign", {31'd0, r_mis}, {31'd0, MisEn});

      // 3. Simultaneous read/write to the same word
      txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 32'h11111111, 1'b0);
      txn(1'b0, 1'b1, 1'b1, 8'h10, 8'h10, 32'h22222222, 1'b0);
      check_eq("rw_old_data", r_rdata, 32'h11111111);
      check_eq("rw_pulses", 32'(r_pulses), 32'd1);
      txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 32'h0, 1'b0);
      check_eq("rw_new_data", r_rdata, 32'h22222222);

      // 4. Inputs changed while busy are ignored
      txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h20, 32'hA5A5A5A5, 1'b0);
      txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 32'h33333333, 1'b1);
      txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 32'h0, 1'b0);
      check_eq("capture_word4", r_rdata, 32'h33333333);
      txn(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 32'h0, 1'b0);
      check_eq("capture_word8", r_rdata, 32'hA5A5A5A5);

      // 5. Reset during the BUSY phase of a write
      txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h08, 32'h0BADF00D, 1'b0);
      @(negedge clk);
      mem_write = 1'b1; waddr = 8'h08; wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      @(negedge clk);
      check_eq("abort_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_rdata", rdata, 32'h0);
      pulses = 0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         if (mem_ready) pulses++;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (mem_ready) pulses++;
      end
      check_eq("abort_no_ready", 32'(pulses), 32'd0);
      txn(1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 32'h0, 1'b0);
      check_eq("abort_no_write", r_rdata, 32'h0BADF00D);

      // 6. Write to an unaligned address
      txn(1'b0, 1'b0, 1'b1, 8'h00, 8'h0A, 32'h12345678, 1'b0);
      check_eq("mis_wr_flag", {31'd0, r_mis}, {31'd0, MisEn});
      check_eq("mis_wr_latency", 32'(r_lat), 32'd2);
      txn(1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 32'h0, 1'b0);
      check_eq("mis_wr_effect", r_rdata, MisEn ? 32'h0BADF00D : 32'h12345678);

      // Zero-wait-state instance
      txn(1'b1, 1'b0, 1'b1, 8'h00, 8'h04, 32'h5555AAAA, 1'b0);
      check_eq("w0_wr_latency", 32'(r_lat), 32'd0);
      check_eq("w0_wr_pulses", 32'(r_pulses), 32'd1);
      check_eq("w0_busy_cycles", 32'(r_busy), 32'd1);
      txn(1'b1, 1'b1, 1'b1, 8'h04, 8'h04, 32'h6666BBBB, 1'b0);
      check_eq("w0_rw_old", r_rdata, 32'h5555AAAA);
      check_eq("w0_rw_latency", 32'(r_lat), 32'd0);
      txn(1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 32'h0, 1'b0);
      check_eq("w0_rd_new", r_rdata, 32'h6666BBBB);
      txn(1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 32'h0BADF00D, 1'b0);
      txn(1'b1, 1'b0, 1'b1, 8'h00, 8'h0A, 32'h12345678, 1'b0);
      check_eq("w0_mis_flag", {31'd0, r_mis}, {31'd0, MisEn});
      check_eq("w0_mis_latency", 32'(r_lat), 32'd0);
      txn(1'b1, 1'b1, 1'b0, 8'h08, 8'h00, 32'h0, 1'b0);
      check_eq("w0_mis_effect", r_rdata, MisEn ? 32'h0BADF00D : 32'h12345678);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
